// File: rtl/b_count_if.sv
// Request/response bundle for the Zbb counting unit: a valid/ready request
// channel carrying op, word mode, operand and tag, and a valid/ready result
// channel carrying the result and the same tag.
interface b_count_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic             in_word;
    logic [WIDTH-1:0] in_operand;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    // Issue side: presents requests and consumes results.
    modport master (
        output in_valid, in_op, in_word, in_operand, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    // Functional unit side.
    modport slave (
        input  in_valid, in_op, in_word, in_operand, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/b_count_unit.sv
// Two-stage Zbb counting unit: cpop/clz/ctz (and their w-variants) plus orc.b.
// S1 reduces every operand byte to popcount, non-zero flag and lowest/highest
// set-bit index; S2 combines the byte summaries into the final result.
// Both stages use valid/ready with full back-pressure; flush kills both stages.
module b_count_unit #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      flush,
    b_count_if.slave  bus
);
    localparam int NB = WIDTH / 8;
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(64'h0000_0000_FFFF_FFFF);

    function automatic logic [3:0] pop8(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
        return n;
    endfunction

    // Scanning downwards so the last hit is the lowest set bit.
    function automatic logic [2:0] low8(input logic [7:0] b);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) if (b[i]) idx = 3'(i);
        return idx;
    endfunction

    // Scanning upwards so the last hit is the highest set bit.
    function automatic logic [2:0] high8(input logic [7:0] b);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) if (b[i]) idx = 3'(i);
        return idx;
    endfunction

    // Pipeline state
    logic                s1_valid_reg;
    logic [1:0]          s1_op_reg;
    logic                s1_word_reg;
    logic [TAG_W-1:0]    s1_tag_reg;
    logic [NB*4-1:0]     s1_pc_reg;
    logic [NB-1:0]       s1_nz_reg;
    logic [NB*3-1:0]     s1_lo_reg;
    logic [NB*3-1:0]     s1_hi_reg;
    logic                s2_valid_reg;
    logic [WIDTH-1:0]    s2_result_reg;
    logic [TAG_W-1:0]    s2_tag_reg;

    // Handshake
    logic s2_adv;
    logic s1_adv;
    logic accept;

    assign s2_adv       = ~s2_valid_reg | bus.out_ready;
    assign s1_adv       = ~s1_valid_reg | s2_adv;
    assign bus.in_ready = s1_adv & ~rst & ~flush;
    assign accept       = bus.in_valid & bus.in_ready;

    // Word mode only narrows the operand on 64-bit builds, and never for orc.b.
    logic             word_eff;
    logic [WIDTH-1:0] operand_eff;
    logic [NB*4-1:0]  pc_next;
    logic [NB-1:0]    nz_next;
    logic [NB*3-1:0]  lo_next;
    logic [NB*3-1:0]  hi_next;

    assign word_eff    = (WIDTH == 64) && bus.in_word && (bus.in_op != 2'b11);
    assign operand_eff = word_eff ? (bus.in_operand & LOW_MASK) : bus.in_operand;

    generate
        for (genvar gi = 0; gi < NB; gi++) begin : g_byte
            logic [7:0] byte_val;
            assign byte_val           = operand_eff[gi*8 +: 8];
            assign pc_next[gi*4 +: 4] = pop8(byte_val);
            assign nz_next[gi]        = |byte_val;
            assign lo_next[gi*3 +: 3] = low8(byte_val);
            assign hi_next[gi*3 +: 3] = high8(byte_val);
        end
    endgenerate

    // Stage valids: cleared by reset or flush, otherwise advance with the handshake.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            s1_valid_reg <= 1'b0;
            s2_valid_reg <= 1'b0;
        end else begin
            if (s1_adv) s1_valid_reg <= bus.in_valid;
            if (s2_adv) s2_valid_reg <= s1_valid_reg;
        end
    end

    // S1 payload: byte summaries captured only on an accepted request.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1_op_reg   <= bus.in_op;
            s1_word_reg <= word_eff;
            s1_tag_reg  <= bus.in_tag;
            s1_pc_reg   <= pc_next;
            s1_nz_reg   <= nz_next;
            s1_lo_reg   <= lo_next;
            s1_hi_reg   <= hi_next;
        end
    end

    // S2 combine: adder tree, priority select over byte flags, or byte fan-out.
    logic [CW-1:0]    n_eff;
    logic [CW-1:0]    cpop_val;
    logic [CW-1:0]    hi_pos;
    logic [CW-1:0]    lo_pos;
    logic [CW-1:0]    clz_val;
    logic [CW-1:0]    ctz_val;
    logic             any_nz;
    logic [WIDTH-1:0] result_next;

    always_comb begin
        n_eff       = s1_word_reg ? CW'(32) : CW'(WIDTH);
        cpop_val    = '0;
        hi_pos      = '0;
        lo_pos      = '0;
        any_nz      = |s1_nz_reg;
        result_next = '0;
        for (int b = 0; b < NB; b++)
            cpop_val = cpop_val + CW'(s1_pc_reg[b*4 +: 4]);
        for (int b = 0; b < NB; b++)
            if (s1_nz_reg[b]) hi_pos = CW'(b*8) + CW'(s1_hi_reg[b*3 +: 3]);
        for (int b = NB - 1; b >= 0; b--)
            if (s1_nz_reg[b]) lo_pos = CW'(b*8) + CW'(s1_lo_reg[b*3 +: 3]);
        clz_val = any_nz ? (n_eff - CW'(1) - hi_pos) : n_eff;
        ctz_val = any_nz ? lo_pos : n_eff;
        case (s1_op_reg)
            2'b00:   result_next[CW-1:0] = cpop_val;
            2'b01:   result_next[CW-1:0] = clz_val;
            2'b10:   result_next[CW-1:0] = ctz_val;
            default: for (int b = 0; b < NB; b++) result_next[b*8 +: 8] = {8{s1_nz_reg[b]}};
        endcase
    end

    // S2 payload: held while stalled so the consumer sees a stable result.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_result_reg <= '0;
            s2_tag_reg    <= '0;
        end else if (s1_valid_reg && s2_adv && !flush) begin
            s2_result_reg <= result_next;
            s2_tag_reg    <= s1_tag_reg;
        end
    end

    assign bus.out_valid  = s2_valid_reg;
    assign bus.out_result = s2_result_reg;
    assign bus.out_tag    = s2_tag_reg;
endmodule

// File: tb/tb_b_count_unit.sv
// Self-checking bench for b_count_unit: directed counting/orc.b vectors,
// back-pressure, flush, reset and a randomised stream on 64- and 32-bit builds.
module tb_b_count_unit;
    logic clk = 1'b0;
    logic rst;
    logic flush;

    always #5 clk = ~clk;

    b_count_if #(.WIDTH(64), .TAG_W(5)) if64 ();
    b_count_if #(.WIDTH(32), .TAG_W(5)) if32 ();

    b_count_unit #(.WIDTH(64), .TAG_W(5)) u64 (.clk(clk), .rst(rst), .flush(flush), .bus(if64));
    b_count_unit #(.WIDTH(32), .TAG_W(5)) u32 (.clk(clk), .rst(rst), .flush(flush), .bus(if32));

    typedef struct packed {
        logic [63:0] res;
        logic [4:0]  tag;
    } exp_t;

    typedef struct packed {
        logic [1:0]  op;
        logic        word;
        logic [63:0] operand;
        logic [63:0] exp;
    } vec_t;

    exp_t q64[$];
    exp_t q32[$];
    int total = 0;
    int bad   = 0;

    // Bit-serial reference model.
    function automatic logic [63:0] model(input int width, input logic [1:0] op,
                                          input logic word, input logic [63:0] x);
        int n;
        int cnt;
        logic [63:0] r;
        n   = (width == 64 && word && op != 2'b11) ? 32 : width;
        cnt = 0;
        r   = '0;
        case (op)
            2'b00: for (int i = 0; i < n; i++) if (x[i]) cnt++;
            2'b01: for (int i = n - 1; i >= 0; i--) begin if (x[i]) break; cnt++; end
            2'b10: for (int i = 0; i < n; i++) begin if (x[i]) break; cnt++; end
            default: for (int b = 0; b < width / 8; b++) r[b*8 +: 8] = (x[b*8 +: 8] != 8'h00) ? 8'hFF : 8'h00;
        endcase
        if (op != 2'b11) r = 64'(cnt);
        return r;
    endfunction

    function automatic logic [63:0] rand_operand();
        int k;
        k = $urandom_range(0, 63);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return ~64'd0;
            2:       return 64'd1 << k;
            3:       return ~64'd0 << k;
            4:       return {32'h0, 32'($urandom())};
            default: return {32'($urandom()), 32'($urandom())};
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        flush = 1'b0;
        if64.in_valid = 1'b1; if64.in_op = 2'b00; if64.in_word = 1'b0;
        if64.in_operand = ~64'd0; if64.in_tag = 5'd3; if64.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.in_op = 2'b00; if32.in_word = 1'b0;
        if32.in_operand = '0; if32.in_tag = '0; if32.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (if64.in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", if64.in_ready); end
        total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", if64.out_valid); end
        total++; if (if64.out_result !== 64'd0) begin bad++; $display("FAIL rst_out_result: got %0h want 0", if64.out_result); end
        total++; if (if64.out_tag !== 5'd0) begin bad++; $display("FAIL rst_out_tag: got %0d want 0", if64.out_tag); end
        @(posedge clk); #1;
        rst = 1'b0;
        if64.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready: got %b want 1", if64.in_ready); end
        @(negedge clk);
        total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL rst_no_accept: got out_valid %b want 0", if64.out_valid); end
        $display("txn reset done");
    endtask

    task automatic test_counts();
        vec_t v[15];
        v[0]  = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd64};
        v[1]  = '{2'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd32};
        v[2]  = '{2'd0, 1'b0, 64'h0000_0000_0000_0000, 64'd0};
        v[3]  = '{2'd1, 1'b0, 64'h0000_0000_0000_0001, 64'd63};
        v[4]  = '{2'd1, 1'b1, 64'hFFFF_FFFF_0000_8000, 64'd16};
        v[5]  = '{2'd2, 1'b0, 64'h8000_0000_0000_0000, 64'd63};
        v[6]  = '{2'd2, 1'b1, 64'h0000_0001_0000_0000, 64'd32};
        v[7]  = '{2'd1, 1'b0, 64'h0000_0000_0000_0000, 64'd64};
        v[8]  = '{2'd3, 1'b0, 64'h0001_0000_8000_0300, 64'h00FF_0000_FF00_FF00};
        v[9]  = '{2'd3, 1'b1, 64'h0001_0000_8000_0300, 64'h00FF_0000_FF00_FF00};
        v[10] = '{2'd1, 1'b1, 64'h0000_0000_0001_0000, 64'd15};
        v[11] = '{2'd2, 1'b0, 64'h0000_0000_0000_0000, 64'd64};
        v[12] = '{2'd1, 1'b1, 64'hFFFF_FFFF_0000_0000, 64'd32};
        v[13] = '{2'd0, 1'b0, 64'h0F0F_0000_0000_0001, 64'd9};
        v[14] = '{2'd2, 1'b1, 64'h0000_0000_8000_0000, 64'd31};
        if64.out_ready = 1'b1;
        foreach (v[i]) begin
            @(posedge clk); #1;
            if64.in_valid = 1'b1; if64.in_op = v[i].op; if64.in_word = v[i].word;
            if64.in_operand = v[i].operand; if64.in_tag = 5'(i + 1);
            @(negedge clk);
            total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL dir%0d_accept: in_ready %b want 1", i, if64.in_ready); end
            @(posedge clk); #1;
            if64.in_valid = 1'b0;
            @(negedge clk);
            total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL dir%0d_early: out_valid %b want 0", i, if64.out_valid); end
            @(negedge clk);
            total++;
            if (if64.out_valid !== 1'b1 || if64.out_result !== v[i].exp || if64.out_tag !== 5'(i + 1)) begin
                bad++;
                $display("FAIL dir%0d_result: got v=%b res=%0h tag=%0d want v=1 res=%0h tag=%0d",
                         i, if64.out_valid, if64.out_result, if64.out_tag, v[i].exp, i + 1);
            end
            $display("txn dir%0d op=%0d word=%0d operand=%h res=%0h tag=%0d", i, v[i].op, v[i].word, v[i].operand, if64.out_result, if64.out_tag);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [63:0] opnd[5];
        int next_tag = 1;
        int outs = 0;
        exp_t e;
        for (int i = 1; i < 5; i++) opnd[i] = rand_operand() | 64'h0000_0100_0000_0010;
        q64.delete();
        if64.out_ready = 1'b0;
        for (int c = 0; c < 40 && outs < 4; c++) begin
            @(posedge clk); #1;
            if (c == 6) if64.out_ready = 1'b1;
            if (next_tag <= 4) begin
                if64.in_valid = 1'b1; if64.in_op = 2'(next_tag - 1); if64.in_word = 1'b0;
                if64.in_operand = opnd[next_tag]; if64.in_tag = 5'(next_tag);
            end else begin
                if64.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                total++;
                if (if64.out_valid !== 1'b1 || if64.out_tag !== 5'd1 || if64.out_result !== q64[0].res) begin
                    bad++;
                    $display("FAIL stall_hold c%0d: got v=%b tag=%0d res=%0h want v=1 tag=1 res=%0h",
                             c, if64.out_valid, if64.out_tag, if64.out_result, q64[0].res);
                end
            end
            if (c == 5) begin
                total++;
                if (next_tag != 3 || if64.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL occupancy: accepted %0d in_ready %b want 2 and 0", next_tag - 1, if64.in_ready);
                end
            end
            if (c == 6) begin
                total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL ready_release: in_ready %b want 1", if64.in_ready); end
            end
            if (if64.in_valid && if64.in_ready) begin
                e.res = model(64, if64.in_op, 1'b0, if64.in_operand);
                e.tag = if64.in_tag;
                q64.push_back(e);
                next_tag++;
            end
            if (if64.out_valid && if64.out_ready) begin
                total++;
                if (q64.size() == 0) begin
                    bad++; $display("FAIL b2b_extra: got tag %0d want none", if64.out_tag);
                end else begin
                    e = q64.pop_front();
                    if (if64.out_result !== e.res || if64.out_tag !== e.tag) begin
                        bad++;
                        $display("FAIL b2b_order: got res=%0h tag=%0d want res=%0h tag=%0d", if64.out_result, if64.out_tag, e.res, e.tag);
                    end
                end
                outs++;
                $display("txn b2b tag=%0d res=%0h", if64.out_tag, if64.out_result);
            end
        end
        total++; if (outs != 4 || next_tag != 5) begin bad++; $display("FAIL b2b_count: got outs=%0d accepted=%0d want 4 and 4", outs, next_tag - 1); end
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_dup: out_valid %b tag %0d want 0", if64.out_valid, if64.out_tag); end
        end
    endtask

    task automatic test_flush();
        if64.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            if64.in_valid = 1'b1; if64.in_op = 2'b00; if64.in_word = 1'b0;
            if64.in_operand = 64'hFF; if64.in_tag = 5'(5 + i);
            @(negedge clk);
            total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL flush_fill%0d: in_ready %b want 1", i, if64.in_ready); end
        end
        @(posedge clk); #1;
        if64.in_tag = 5'd7;
        flush = 1'b1;
        @(negedge clk);
        total++; if (if64.in_ready !== 1'b0) begin bad++; $display("FAIL flush_accept: in_ready %b want 0", if64.in_ready); end
        @(posedge clk); #1;
        flush = 1'b0;
        if64.in_valid = 1'b0;
        if64.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL flush_clear%0d: out_valid %b tag %0d want 0", i, if64.out_valid, if64.out_tag); end
        end
        @(posedge clk); #1;
        if64.in_valid = 1'b1; if64.in_op = 2'b10; if64.in_word = 1'b0;
        if64.in_operand = 64'h0000_0100_0000_0000; if64.in_tag = 5'd8;
        @(negedge clk);
        total++; if (if64.in_ready !== 1'b1) begin bad++; $display("FAIL flush_resume_accept: in_ready %b want 1", if64.in_ready); end
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        @(negedge clk);
        total++; if (if64.out_valid !== 1'b0) begin bad++; $display("FAIL flush_resume_early: out_valid %b want 0", if64.out_valid); end
        @(negedge clk);
        total++;
        if (if64.out_valid !== 1'b1 || if64.out_result !== 64'd40 || if64.out_tag !== 5'd8) begin
            bad++;
            $display("FAIL flush_resume: got v=%b res=%0h tag=%0d want v=1 res=28 tag=8", if64.out_valid, if64.out_result, if64.out_tag);
        end
        $display("txn flush resume tag=%0d res=%0d", if64.out_tag, if64.out_result);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        if64.out_ready = 1'b0;
        @(posedge clk); #1;
        if64.in_valid = 1'b1; if64.in_op = 2'b11; if64.in_word = 1'b0;
        if64.in_operand = 64'h1234; if64.in_tag = 5'd9;
        @(posedge clk); #1;
        if64.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (if64.out_valid !== 1'b1 || if64.out_result !== 64'hFFFF || if64.out_tag !== 5'd9) begin
            bad++;
            $display("FAIL midrst_before: got v=%b res=%0h tag=%0d want v=1 res=ffff tag=9", if64.out_valid, if64.out_result, if64.out_tag);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        total++; if (if64.in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready: got %b want 0", if64.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        if64.out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (if64.out_valid !== 1'b0 || if64.out_result !== 64'd0 || if64.out_tag !== 5'd0 || if64.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_after: got v=%b res=%0h tag=%0d rdy=%b want 0 0 0 1",
                     if64.out_valid, if64.out_result, if64.out_tag, if64.in_ready);
        end
        $display("txn mid-reset tag=%0d res=%0h", if64.out_tag, if64.out_result);
    endtask

    task automatic test_random(input int cycles);
        logic acc64 = 1'b0;
        logic acc32 = 1'b0;
        logic [63:0] t;
        exp_t e;
        q64.delete();
        q32.delete();
        if64.in_valid = 1'b0;
        if32.in_valid = 1'b0;
        for (int c = 0; c < cycles + 40; c++) begin
            @(posedge clk); #1;
            if (acc64 || !if64.in_valid) begin
                if64.in_valid   = (c < cycles) && ($urandom_range(0, 3) != 0);
                if64.in_op      = 2'($urandom_range(0, 3));
                if64.in_word    = 1'($urandom_range(0, 1));
                if64.in_operand = rand_operand();
                if64.in_tag     = 5'($urandom_range(0, 31));
            end
            if (acc32 || !if32.in_valid) begin
                t = rand_operand();
                if32.in_valid   = (c < cycles) && ($urandom_range(0, 3) != 0);
                if32.in_op      = 2'($urandom_range(0, 3));
                if32.in_word    = 1'($urandom_range(0, 1));
                if32.in_operand = ($urandom_range(0, 1) != 0) ? t[31:0] : t[63:32];
                if32.in_tag     = 5'($urandom_range(0, 31));
            end
            if64.out_ready = (c >= cycles) || ($urandom_range(0, 2) != 0);
            if32.out_ready = (c >= cycles) || ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc64 = if64.in_valid && if64.in_ready;
            acc32 = if32.in_valid && if32.in_ready;
            if (acc64) begin
                e.res = model(64, if64.in_op, if64.in_word, if64.in_operand);
                e.tag = if64.in_tag;
                q64.push_back(e);
            end
            if (acc32) begin
                e.res = model(32, if32.in_op, if32.in_word, {32'h0, if32.in_operand});
                e.tag = if32.in_tag;
                q32.push_back(e);
            end
            if (if64.out_valid && if64.out_ready) begin
                total++;
                if (q64.size() == 0) begin
                    bad++; $display("FAIL rnd64_extra: got tag %0d want none", if64.out_tag);
                end else begin
                    e = q64.pop_front();
                    if (if64.out_result !== e.res || if64.out_tag !== e.tag) begin
                        bad++;
                        $display("FAIL rnd64: got res=%0h tag=%0d want res=%0h tag=%0d", if64.out_result, if64.out_tag, e.res, e.tag);
                    end
                    $display("txn rnd64 res=%0h tag=%0d", if64.out_result, if64.out_tag);
                end
            end
            if (if32.out_valid && if32.out_ready) begin
                total++;
                if (q32.size() == 0) begin
                    bad++; $display("FAIL rnd32_extra: got tag %0d want none", if32.out_tag);
                end else begin
                    e = q32.pop_front();
                    if ({32'h0, if32.out_result} !== e.res || if32.out_tag !== e.tag) begin
                        bad++;
                        $display("FAIL rnd32: got res=%0h tag=%0d want res=%0h tag=%0d", if32.out_result, if32.out_tag, e.res, e.tag);
                    end
                    $display("txn rnd32 res=%0h tag=%0d", if32.out_result, if32.out_tag);
                end
            end
        end
        total++; if (q64.size() != 0) begin bad++; $display("FAIL rnd64_drain: got %0d pending want 0", q64.size()); end
        total++; if (q32.size() != 0) begin bad++; $display("FAIL rnd32_drain: got %0d pending want 0", q32.size()); end
    endtask

    initial begin
        test_reset();
        test_counts();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random(250);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
